dot8_acc: RTL and testbench

- Sequential dot-product controller that sits around the team's combinational 8-bit array multiplier.
- Accepts a burst of N_TERMS 8-bit operand pairs over a valid/ready handshake and registers each pair onto the multiplier inputs.
- Consumes the 16-bit product one cycle later and accumulates it.
- Presents the final sum on a valid/ready output; the multiplier instance lives in the parent and is wired to mul_x/mul_y/mul_z.

---
 rtl/dot8_acc_pkg.sv | 14 +
 rtl/dot8_acc.sv | 110 +++++++++++
 tb/tb_dot8_acc.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/dot8_acc_pkg.sv
// rtl/dot8_acc_pkg.sv - shared state encoding and datapath widths for dot8_acc
package dot8_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_e;

  localparam int OPW   = 8;
  localparam int PRODW = 16;

endpackage

// File: rtl/dot8_acc.sv
// rtl/dot8_acc.sv - dot-product controller around an external 8x8 multiplier
// Operands are registered onto mul_x/mul_y; the product is accumulated one cycle later.
module dot8_acc
  import dot8_acc_pkg::*;
#(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   a,
  input  logic [OPW-1:0]   b,
  output logic [OPW-1:0]   mul_x,
  output logic [OPW-1:0]   mul_y,
  input  logic [PRODW-1:0] mul_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             busy,
  output logic             ovf
);

  localparam int CNT_W = $clog2(N_TERMS + 1);
  localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_TERMS);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic               p_valid_q, p_valid_d;
  logic [OPW-1:0]     mul_x_q, mul_x_d;
  logic [OPW-1:0]     mul_y_q, mul_y_d;
  logic [ACC_W:0]     sum;
  logic               xfer;

  assign in_ready  = (state_q == ACCUM) && (cnt_q < N_LAST);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign out_data  = acc_q;
  assign ovf       = ovf_q;
  assign mul_x     = mul_x_q;
  assign mul_y     = mul_y_q;
  assign xfer      = in_valid && in_ready;
  assign sum       = {1'b0, acc_q} + {{(ACC_W + 1 - PRODW){1'b0}}, mul_z};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    p_valid_d = 1'b0;
    mul_x_d   = mul_x_q;
    mul_y_d   = mul_y_q;

    // The product of the pair registered last cycle is on mul_z now.
    if (p_valid_q) begin
      acc_d = sum[ACC_W-1:0];
      if (sum[ACC_W]) ovf_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (xfer) begin
          mul_x_d   = a;
          mul_y_d   = b;
          p_valid_d = 1'b1;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q + 1'b1 == N_LAST) state_d = DRAIN;
        end
      end
      DRAIN: state_d = HOLD;
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      p_valid_q <= 1'b0;
      mul_x_q   <= '0;
      mul_y_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      p_valid_q <= p_valid_d;
      mul_x_q   <= mul_x_d;
      mul_y_q   <= mul_y_d;
    end
  end

endmodule

// File: tb/tb_dot8_acc.sv
// tb/tb_dot8_acc.sv - directed self-checking bench for dot8_acc
// Two instances: N_TERMS=4/ACC_W=20 and N_TERMS=2/ACC_W=16; the bench models the multiplier.
module tb_dot8_acc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start, in_valid, in_ready, out_valid, out_ready, busy, ovf;
  logic [7:0]  a, b, mul_x, mul_y;
  logic [15:0] mul_z;
  logic [19:0] out_data;

  logic        s_start, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy, s_ovf;
  logic [7:0]  s_a, s_b, s_mul_x, s_mul_y;
  logic [15:0] s_mul_z;
  logic [15:0] s_out_data;

  int checks   = 0;
  int failures = 0;

  assign mul_z   = mul_x * mul_y;
  assign s_mul_z = s_mul_x * s_mul_y;

  dot8_acc #(.N_TERMS(4), .ACC_W(20)) u_dut20 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mul_x(mul_x), .mul_y(mul_y), .mul_z(mul_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .ovf(ovf)
  );

  dot8_acc #(.N_TERMS(2), .ACC_W(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a(s_a), .b(s_b), .mul_x(s_mul_x), .mul_y(s_mul_y), .mul_z(s_mul_z),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .busy(s_busy), .ovf(s_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_out_ready();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // Presents one pair, waits (bounded) for acceptance, then idles for gap cycles.
  task automatic send(input logic [7:0] av, input logic [7:0] bv, input int gap);
    int n;
    in_valid = 1'b1;
    a = av;
    b = bv;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (gap) begin
      chk("gap_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 0; in_valid = 0; out_ready = 0; a = 0; b = 0;
    s_start = 0; s_in_valid = 0; s_out_ready = 0; s_a = 0; s_b = 0;
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_mul_x", {24'd0, mul_x}, 32'd0);
    chk("rst_out_data", {12'd0, out_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back burst
    pulse_start();
    chk("t1_busy", {31'd0, busy}, 32'd1);
    send(8'd3, 8'd5, 0);
    send(8'd7, 8'd11, 0);
    send(8'd255, 8'd255, 0);
    send(8'd0, 8'd200, 0);
    chk("t1_drain_no_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("t1_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_out_data", {12'd0, out_data}, 32'd65117);
    chk("t1_ovf", {31'd0, ovf}, 32'd0);
    chk("t1_mul_y_hold", {24'd0, mul_y}, 32'd200);
    chk("t1_in_ready_hold", {31'd0, in_ready}, 32'd0);

    // Backpressure in HOLD
    repeat (5) begin
      @(negedge clk);
      chk("t3_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("t3_hold_data", {12'd0, out_data}, 32'd65117);
    end
    pulse_out_ready();
    chk("t3_idle_valid", {31'd0, out_valid}, 32'd0);
    chk("t3_idle_busy", {31'd0, busy}, 32'd0);

    // Gapped burst
    pulse_start();
    send(8'd3, 8'd5, 2);
    send(8'd7, 8'd11, 2);
    send(8'd255, 8'd255, 2);
    send(8'd0, 8'd200, 0);
    @(negedge clk);
    chk("t2_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t2_out_data", {12'd0, out_data}, 32'd65117);
    pulse_out_ready();

    // Spurious start in ACCUM and HOLD
    pulse_start();
    send(8'd3, 8'd5, 0);
    send(8'd7, 8'd11, 0);
    pulse_start();
    chk("t5_accum_ready", {31'd0, in_ready}, 32'd1);
    send(8'd255, 8'd255, 0);
    send(8'd0, 8'd200, 0);
    @(negedge clk);
    pulse_start();
    chk("t5_hold_valid", {31'd0, out_valid}, 32'd1);
    chk("t5_hold_data", {12'd0, out_data}, 32'd65117);
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b0;
    chk("t5_handshake_idle", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("t5_start_ignored", {31'd0, busy}, 32'd0);

    // ACC_W=16 wraparound
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    s_in_valid = 1'b1;
    s_a = 8'd255;
    s_b = 8'd255;
    chk("w_in_ready", {31'd0, s_in_ready}, 32'd1);
    repeat (2) @(negedge clk);
    s_in_valid = 1'b0;
    chk("w_drain", {31'd0, s_out_valid}, 32'd0);
    @(negedge clk);
    chk("w_out_valid", {31'd0, s_out_valid}, 32'd1);
    chk("w_out_data", {16'd0, s_out_data}, 32'd64514);
    chk("w_ovf", {31'd0, s_ovf}, 32'd1);
    s_out_ready = 1'b1;
    @(negedge clk);
    s_out_ready = 1'b0;
    chk("w_ovf_sticky_idle", {31'd0, s_ovf}, 32'd1);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    chk("w_ovf_cleared", {31'd0, s_ovf}, 32'd0);
    chk("w_acc_cleared", {16'd0, s_out_data}, 32'd0);

    // Asynchronous reset mid-burst
    pulse_start();
    send(8'd9, 8'd9, 0);
    send(8'd9, 8'd9, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_in_ready", {31'd0, in_ready}, 32'd0);
    chk("ar_mul_x", {24'd0, mul_x}, 32'd0);
    chk("ar_mul_y", {24'd0, mul_y}, 32'd0);
    chk("ar_out_data", {12'd0, out_data}, 32'd0);
    chk("ar_out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ar_stay_idle", {31'd0, busy}, 32'd0);
    pulse_start();
    repeat (4) send(8'd1, 8'd1, 0);
    @(negedge clk);
    chk("ar_out_valid_after", {31'd0, out_valid}, 32'd1);
    chk("ar_out_data_after", {12'd0, out_data}, 32'd4);
    pulse_out_ready();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
